// File: rtl/md_unit.sv
// HI/LO multiply-divide unit for the E stage.
// Fixed-latency mult/div with mfhi/mflo/mthi/mtlo and hazard stall.
module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hilo_out
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
    logic        wr_q, wr_d;

    logic op_mult, op_multu, op_div, op_divu;
    logic op_mfhi, op_mflo, op_mthi, op_mtlo;
    logic is_md, is_hl;

    assign op_mult  = (op == 4'd1);
    assign op_multu = (op == 4'd2);
    assign op_div   = (op == 4'd3);
    assign op_divu  = (op == 4'd4);
    assign op_mfhi  = (op == 4'd5);
    assign op_mflo  = (op == 4'd6);
    assign op_mthi  = (op == 4'd7);
    assign op_mtlo  = (op == 4'd8);
    assign is_md    = op_mult | op_multu | op_div | op_divu;
    assign is_hl    = (op >= 4'd1) && (op <= 4'd8);

    assign busy  = (state_q == BUSY);
    assign start = is_md & ~req & ~busy;
    assign stall = (busy | start) & is_hl;

    always_comb begin
        hilo_out = 32'd0;
        if (op_mfhi) hilo_out = hi_q;
        if (op_mflo) hilo_out = lo_q;
    end

    // One 64-bit multiplier: the low 64 bits of a product of
    // sign-extended operands equal the signed product.
    logic [31:0] ext_a, ext_b;
    logic [63:0] prod;

    assign ext_a = op_mult ? {32{rs_data[31]}} : 32'd0;
    assign ext_b = op_mult ? {32{rt_data[31]}} : 32'd0;
    assign prod  = {ext_a, rs_data} * {ext_b, rt_data};

    // Signed divide runs on magnitudes, which also makes
    // 0x80000000 / -1 wrap cleanly to 0x80000000.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, dvd, dvs, quo, rem;

    assign a_neg = op_div & rs_data[31];
    assign b_neg = op_div & rt_data[31];
    assign a_mag = a_neg ? -rs_data : rs_data;
    assign b_mag = b_neg ? -rt_data : rt_data;
    assign dvd   = a_mag;
    assign dvs   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign quo   = dvd / dvs;
    assign rem   = dvd % dvs;

    logic [31:0] res_hi, res_lo;
    logic        res_ok;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_ok = 1'b0;
        unique case (1'b1)
            op_mult, op_multu: begin
                res_hi = prod[63:32];
                res_lo = prod[31:0];
                res_ok = 1'b1;
            end
            op_div, op_divu: begin
                res_lo = (a_neg ^ b_neg) ? -quo : quo;
                res_hi = a_neg ? -rem : rem;
                res_ok = (rt_data != 32'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        wr_d     = wr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = BUSY;
                    cnt_d    = (op_mult | op_multu) ? 4'd5 : 4'd10;
                    hi_tmp_d = res_hi;
                    lo_tmp_d = res_lo;
                    wr_d     = res_ok;
                end else if (!req) begin
                    if (op_mthi) hi_d = rs_data;
                    if (op_mtlo) lo_d = rs_data;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    if (wr_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            wr_q     <= wr_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random
// traffic compared every cycle against a behavioural model.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        req;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] hilo_out;

    int n_checks = 0;
    int n_err    = 0;

    md_unit dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .req      (req),
        .start    (start),
        .busy     (busy),
        .stall    (stall),
        .hilo_out (hilo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: architectural HI/LO, cycles of latency left, pending result.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left;
    logic        m_wr;

    function automatic logic [64:0] model_res(input logic [3:0] o,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        logic [31:0] uq, ur;
        model_res = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 4'd1) begin
            p = 64'(sa * sb);
            model_res = {1'b1, p};
        end else if (o == 4'd2) begin
            p = {32'd0, a} * {32'd0, b};
            model_res = {1'b1, p};
        end else if (o == 4'd3 && b != 0) begin
            q = sa / sb;
            r = sa % sb;
            model_res = {1'b1, r[31:0], q[31:0]};
        end else if (o == 4'd4 && b != 0) begin
            uq = a / b;
            ur = a % b;
            model_res = {1'b1, ur, uq};
        end
    endfunction

    function automatic logic exp_busy();
        return m_left > 0;
    endfunction

    function automatic logic exp_start();
        return (op >= 4'd1 && op <= 4'd4) && !req && !exp_busy();
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi <= 0; m_lo <= 0; m_phi <= 0; m_plo <= 0;
            m_left <= 0; m_wr <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_wr) begin
                m_hi <= m_phi;
                m_lo <= m_plo;
            end
        end else if (exp_start()) begin
            {m_wr, m_phi, m_plo} <= model_res(op, rs_data, rt_data);
            m_left <= (op <= 4'd2) ? 5 : 10;
        end else if (!req) begin
            if (op == 4'd7) m_hi <= rs_data;
            if (op == 4'd8) m_lo <= rs_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e_hilo;
        logic        e_stall;
        e_hilo  = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        e_stall = (exp_busy() || exp_start()) && op >= 4'd1 && op <= 4'd8;
        chk("cyc_busy", 32'(busy), 32'(exp_busy()));
        chk("cyc_start", 32'(start), 32'(exp_start()));
        chk("cyc_stall", 32'(stall), 32'(e_stall));
        chk("cyc_hilo", hilo_out, e_hilo);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic r);
        op = o; rs_data = a; rt_data = b; req = r;
    endtask

    task automatic peek(input logic [3:0] o, input string name,
                        input logic [31:0] exp);
        op = o;
        #1;
        chk(name, hilo_out, exp);
    endtask

    task automatic run(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int lat);
        drive(o, a, b, 1'b0);
        #1;
        chk("run_start", 32'(start), 32'd1);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < lat; i++) begin
            #1;
            chk("run_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("run_done", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        drive(4'd5, 32'd0, 32'd0, 1'b0);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hilo_out, 32'd0);
        #11 reset = 1'b1;
        tick();

        drive(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        tick();
        drive(4'd6, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("mflo_stall", 32'(stall), 32'd1);
            tick();
        end
        #1;
        chk("mult_lo", hilo_out, 32'hFFFFFFFA);
        chk("mflo_nostall", 32'(stall), 32'd0);
        peek(4'd5, "mult_hi", 32'hFFFFFFFF);

        run(4'd2, 32'hFFFFFFFE, 32'd3, 5);
        peek(4'd5, "multu_hi", 32'h00000002);
        peek(4'd6, "multu_lo", 32'hFFFFFFFA);

        run(4'd3, 32'hFFFFFFF9, 32'd2, 10);
        peek(4'd6, "div_lo", 32'hFFFFFFFD);
        peek(4'd5, "div_hi", 32'hFFFFFFFF);

        drive(4'd7, 32'h12345678, 32'd0, 1'b0);
        tick();
        drive(4'd8, 32'h12345678, 32'd0, 1'b0);
        tick();
        run(4'd4, 32'd7, 32'd0, 10);
        peek(4'd5, "div0_hi", 32'h12345678);
        peek(4'd6, "div0_lo", 32'h12345678);

        drive(4'd7, 32'hA5A5A5A5, 32'd0, 1'b1);
        tick();
        peek(4'd5, "mthi_req", 32'h12345678);
        drive(4'd7, 32'hA5A5A5A5, 32'd0, 1'b0);
        tick();
        peek(4'd5, "mthi", 32'hA5A5A5A5);
        chk("mfhi_stall", 32'(stall), 32'd0);

        run(4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
        peek(4'd6, "ovf_lo", 32'h80000000);
        peek(4'd5, "ovf_hi", 32'h00000000);

        drive(4'd1, 32'd9, 32'd9, 1'b1);
        #1;
        chk("req_start", 32'(start), 32'd0);
        tick();
        chk("req_busy", 32'(busy), 32'd0);
        peek(4'd6, "req_lo", 32'h80000000);

        drive(4'd3, 32'd100, 32'd7, 1'b0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        peek(4'd5, "rst_mid_hi", 32'd0);
        peek(4'd6, "rst_mid_lo", 32'd0);
        reset = 1'b1;
        run(4'd2, 32'd3, 32'd4, 5);
        peek(4'd6, "post_rst_lo", 32'd12);

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, b;
            int sel;
            a = $urandom();
            b = $urandom();
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if (sel == 2) b = $urandom_range(1, 16);
            drive(4'($urandom_range(0, 15)), a, b,
                  ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                #1;
                reset = 1'b1;
            end
            tick();
        end

        drive(4'd0, 32'd0, 32'd0, 1'b0);
        repeat (12) tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as the codebase names them (clk, reset).
REQ-002 clk  input  1  rising-edge clock; all state SHALL be updated on this edge.
REQ-003 reset  input  1  asynchronous, active-low; reset = 0 SHALL clear all state immediately.
REQ-004 op  input  4  E-stage HI/LO operation code from the decoder: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 treated as none.
REQ-005 rs_data  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
REQ-006 rt_data  input  32  forwarded rt operand (divisor / multiplier).
REQ-007 req  input  1  exception/interrupt flush of the E stage; when high, this cycle's op SHALL have no effect.
REQ-008 start  output  1  combinational; high when op is 1-4, req = 0 and busy = 0.
REQ-009 busy  output  1  registered; high while an operation is in flight.
REQ-010 stall  output  1  combinational; (busy or start) and op is 1-8; this output drives the hazard unit.
REQ-011 hilo_out  output  32  combinational; HI when op = 5, LO when op = 6, otherwise 0.

Function
REQ-012 Operation SHALL be accepted only in a cycle where start = 1.
- At that edge, operands SHALL be captured and the result computed into internal hi_tmp/lo_tmp.
- A down-counter SHALL be loaded with 5 for op 1-2, or 10 for op 3-4.
REQ-013 State machine: IDLE --(start)--> BUSY; BUSY --(counter = 1 at edge)--> IDLE. HI/LO SHALL be written from hi_tmp/lo_tmp on that same final edge.
REQ-014 busy SHALL be 1 for exactly 5 (mult/multu) or 10 (div/divu) cycles, starting the cycle after start. HI/LO SHALL become visible on hilo_out in the first cycle busy = 0.
REQ-015 mult: {HI,LO} = signed 64-bit product. multu: {HI,LO} = unsigned 64-bit product.
REQ-016 div: LO = signed quotient, truncated toward zero; HI = remainder carrying the sign of the dividend. divu: the unsigned equivalents.
REQ-017 Divide by zero (rt_data = 0, op 3/4): busy SHALL run the full 10 cycles; HI and LO SHALL remain unchanged.
REQ-018 div 0x80000000 / 0xFFFFFFFF SHALL yield LO = 0x80000000, HI = 0.
REQ-019 mthi/mtlo with req = 0 and busy = 0 SHALL write rs_data to HI/LO at the next edge. Writes SHALL be ignored when req = 1 or busy = 1, since the hazard unit stalls in that case.
REQ-020 While busy = 1, op 1-4 SHALL NOT start and SHALL NOT disturb the in-flight operation, counter or tmp registers.
REQ-021 req SHALL NOT abort an in-flight operation; it SHALL block only a new start and mthi/mtlo in the same cycle.
REQ-022 mfhi/mflo during the final busy cycle SHALL return the old HI/LO, and stall SHALL be high.
REQ-023 Back-to-back operation: a new start SHALL be accepted in the first cycle with busy = 0.

Reset
REQ-024 reset = 0 SHALL immediately force HI = 0, LO = 0, hi_tmp = lo_tmp = 0, counter = 0, busy = 0 and state = IDLE, regardless of the clock.
REQ-025 Reset asserted mid-operation SHALL discard the pending result; HI and LO SHALL read 0 after release.
REQ-026 After reset release, the first edge SHALL accept a new operation normally.

Verification
REQ-027 mult with rs = 0xFFFFFFFE (-2), rt = 3 -> busy high 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. multu with the same operands -> HI = 0x00000002, LO = 0xFFFFFFFA.
REQ-028 div with rs = 0xFFFFFFF9 (-7), rt = 2 -> busy high 10 cycles; then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. divu 7/0 with HI = LO = 0x12345678 beforehand -> HI and LO unchanged after 10 cycles.
REQ-029 mthi 0xA5A5A5A5 with req = 1 -> HI unchanged. Same op with req = 0 -> mfhi next cycle returns 0xA5A5A5A5 with stall = 0.
REQ-030 mult started, then mflo held on op for the following cycles -> stall = 1 for 5 cycles; hilo_out = new LO in cycle 6.
REQ-031 div started, reset pulsed low at busy cycle 4 -> busy = 0 immediately; HI = LO = 0; a following multu 3*4 completes with LO = 12.
REQ-032 mult start with req = 1 -> start = 0, busy stays 0, HI and LO unchanged.
